// File: rtl/conv_host_seq_if.sv
// conv_host_seq_if: signal bundle between the host sequencer, the system
// byte interface and the convolution core.
//   s_data/s_vld/s_rdy   : input byte stream (valid/ready)
//   data_lin/in_vld      : assembled frame and level request to the core
//   conv_lin/out_vld     : core result and result valid
//   m_data/m_vld/m_rdy   : result byte stream (valid/ready)
//   busy, frame_cnt      : status
// master = sequencer side, slave = environment (byte source, core, sink).
interface conv_host_seq_if #(
    parameter int unsigned IN_BYTES  = 64,
    parameter int unsigned OUT_BYTES = 108
);
    logic [7:0]             s_data;
    logic                   s_vld;
    logic                   s_rdy;
    logic [IN_BYTES*8-1:0]  data_lin;
    logic                   in_vld;
    logic [OUT_BYTES*8-1:0] conv_lin;
    logic                   out_vld;
    logic [7:0]             m_data;
    logic                   m_vld;
    logic                   m_rdy;
    logic                   busy;
    logic [15:0]            frame_cnt;

    modport master (
        input  s_data, s_vld, conv_lin, out_vld, m_rdy,
        output s_rdy, data_lin, in_vld, m_data, m_vld, busy, frame_cnt
    );

    modport slave (
        output s_data, s_vld, conv_lin, out_vld, m_rdy,
        input  s_rdy, data_lin, in_vld, m_data, m_vld, busy, frame_cnt
    );
endinterface

// File: rtl/conv_host_seq.sv
// conv_host_seq: initiator-side sequencer for the convolution core.
// Collects IN_BYTES input bytes into data_lin, holds in_vld until a fresh
// rising edge of out_vld, captures conv_lin, waits GAP idle cycles and then
// streams the OUT_BYTES result bytes out on m_data/m_vld/m_rdy.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : conv_host_seq_if.master (byte in, core handshake, byte out,
//            busy and completed-frame counter)
// Every output is a register or a direct copy of one.
module conv_host_seq #(
    parameter int unsigned IN_BYTES  = 64,
    parameter int unsigned OUT_BYTES = 108,
    parameter int unsigned GAP       = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    conv_host_seq_if.master bus
);
    localparam int unsigned IW = (IN_BYTES > 1)  ? $clog2(IN_BYTES)  : 1;
    localparam int unsigned OW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
    localparam int unsigned GW = (GAP > 1)       ? $clog2(GAP)       : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(IN_BYTES - 1);
    localparam logic [OW-1:0] ODX_LAST = OW'(OUT_BYTES - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_REQ,
        S_GAP,
        S_DRAIN
    } state_t;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [OW-1:0]           odx;
    logic [GW-1:0]           gap_cnt;
    logic                    ovq;
    logic [IN_BYTES-1:0][7:0]  dbuf;
    logic [OUT_BYTES-1:0][7:0] rbuf;

    logic                    s_rdy_q;
    logic                    in_vld_q;
    logic                    m_vld_q;
    logic [7:0]              m_data_q;
    logic                    busy_q;
    logic [15:0]             frame_cnt_q;

    assign bus.s_rdy     = s_rdy_q;
    assign bus.in_vld    = in_vld_q;
    assign bus.m_vld     = m_vld_q;
    assign bus.m_data    = m_data_q;
    assign bus.busy      = busy_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.data_lin  = dbuf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_LOAD;
            idx         <= '0;
            odx         <= '0;
            gap_cnt     <= '0;
            ovq         <= 1'b0;
            dbuf        <= '0;
            rbuf        <= '0;
            s_rdy_q     <= 1'b1;
            in_vld_q    <= 1'b0;
            m_vld_q     <= 1'b0;
            m_data_q    <= '0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            // Tracked in every state so a result valid left high by the
            // previous frame is already seen as "old" when REQ is entered.
            ovq <= bus.out_vld;

            unique case (state)
                S_LOAD: begin
                    if (bus.s_vld && s_rdy_q) begin
                        dbuf[idx] <= bus.s_data;
                        // busy is kept as a flag rather than decoded from idx
                        // so it stays a plain register output.
                        busy_q    <= 1'b1;
                        if (idx == IDX_LAST) begin
                            idx      <= '0;
                            s_rdy_q  <= 1'b0;
                            in_vld_q <= 1'b1;
                            state    <= S_REQ;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end

                S_REQ: begin
                    // Capture on a rising edge of out_vld only.
                    if (bus.out_vld && !ovq) begin
                        rbuf     <= bus.conv_lin;
                        gap_cnt  <= GAP_LOAD;
                        in_vld_q <= 1'b0;
                        state    <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == '0) begin
                        m_vld_q  <= 1'b1;
                        m_data_q <= rbuf[0];
                        state    <= S_DRAIN;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end

                S_DRAIN: begin
                    if (m_vld_q && bus.m_rdy) begin
                        if (odx == ODX_LAST) begin
                            odx         <= '0;
                            m_vld_q     <= 1'b0;
                            s_rdy_q     <= 1'b1;
                            busy_q      <= 1'b0;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            state       <= S_LOAD;
                        end else begin
                            // Preload the next byte so m_data stays registered.
                            odx      <= odx + OW'(1);
                            m_data_q <= rbuf[odx + OW'(1)];
                        end
                    end
                end

                default: state <= S_LOAD;
            endcase
        end
    end
endmodule
